// File: rtl/scene_sequencer.sv
// scene_sequencer: top-level scene controller IDLE -> MENU -> PLAY -> RESULT -> MENU ...
// Each active scene has a watchdog. When the watchdog expires, the sequencer
// parks in ERROR until the next start event.
//
// Optional feature: define SCENE_BUSY_CHECK_EN to require menu_busy_in to be
// seen high within the first 4 cycles of every MENU entry.
//
// Parameters:
//   TIMEOUT_CYCLES    per-scene watchdog limit in clk cycles (>= 2)
//   IDLE_CODE         state code driven while idle
// Ports:
//   clk               system clock, rising edge
//   rst               synchronous active-high reset
//   btn_start_in      debounced start button (level)
//   menu_busy_in      menu busy level (only used with SCENE_BUSY_CHECK_EN)
//   menu_finished_in  one-cycle done pulse from the menu scene
//   play_finished_in  one-cycle done pulse from the play scene
//   result_finished_in one-cycle done pulse from the result scene
//   state_out         registered scene code (also serves as the FSM debug view)
//   scene_start_out   one-cycle pulse in the first cycle of a new state_out value
//   timeout_out       high while in ERROR
//
// Handshake note: the *_finished_in inputs are single-cycle strobes with no
// ready/acknowledge. A strobe counts only when it is sampled in the state it
// belongs to; otherwise it is dropped.
module scene_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 40000000,
  parameter logic [3:0]  IDLE_CODE      = 4'b1010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_in,
  input  logic       menu_busy_in,
  input  logic       menu_finished_in,
  input  logic       play_finished_in,
  input  logic       result_finished_in,
  output logic [3:0] state_out,
  output logic       scene_start_out,
  output logic       timeout_out
);

  localparam logic [3:0]  MENU     = 4'b0000;
  localparam logic [3:0]  PLAY     = 4'b0001;
  localparam logic [3:0]  RESULT   = 4'b0010;
  localparam logic [3:0]  ERROR    = 4'b1111;
  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);

  logic [3:0]  state_q;
  logic [3:0]  next_state;
  logic        scene_start_q;
  logic        timeout_q;
  logic [31:0] watchdog;
  logic        btn_q;
  logic        start_ev;
  logic        in_scene;
  logic        wd_expired;
  logic        state_change;

  // btn_q resets to 1 so that a button held through reset does not create an edge.
  assign start_ev     = btn_start_in & ~btn_q;
  assign in_scene     = (state_q == MENU) || (state_q == PLAY) || (state_q == RESULT);
  assign wd_expired   = (watchdog == WD_LIMIT);
  assign state_change = (next_state != state_q);

`ifdef SCENE_BUSY_CHECK_EN
  logic busy_seen;
  logic busy_missed;
  // The watchdog doubles as the MENU age counter: it reads 0 in the entry
  // cycle, so age 3 is the last cycle of the 4-cycle window.
  assign busy_missed = (watchdog == 32'd3) && !busy_seen && !menu_busy_in;
`else
  logic unused_busy;
  assign unused_busy = menu_busy_in;
`endif

  // Within each active state the matching done pulse is checked first, so it
  // wins over a watchdog (or busy) expiry that happens in the same cycle.
  always_comb begin
    next_state = state_q;
    case (state_q)
      MENU: begin
        if (menu_finished_in)  next_state = PLAY;
        else if (wd_expired)   next_state = ERROR;
`ifdef SCENE_BUSY_CHECK_EN
        else if (busy_missed)  next_state = ERROR;
`endif
      end
      PLAY: begin
        if (play_finished_in)  next_state = RESULT;
        else if (wd_expired)   next_state = ERROR;
      end
      RESULT: begin
        if (result_finished_in) next_state = MENU;
        else if (wd_expired)    next_state = ERROR;
      end
      ERROR: begin
        if (start_ev)          next_state = IDLE_CODE;
      end
      default: begin
        // IDLE, and any unexpected code, which is treated as idle.
        if (start_ev)          next_state = MENU;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE_CODE;
      scene_start_q <= 1'b0;
      timeout_q     <= 1'b0;
      watchdog      <= 32'd0;
      btn_q         <= 1'b1;
    end else begin
      btn_q         <= btn_start_in;
      state_q       <= next_state;
      scene_start_q <= state_change;
      timeout_q     <= (next_state == ERROR);
      if (state_change)  watchdog <= 32'd0;
      else if (in_scene) watchdog <= watchdog + 32'd1;
      else               watchdog <= 32'd0;
    end
  end

`ifdef SCENE_BUSY_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                                     busy_seen <= 1'b0;
    else if (state_change)                       busy_seen <= 1'b0;
    else if ((state_q == MENU) && menu_busy_in)  busy_seen <= 1'b1;
  end
`endif

  assign state_out       = state_q;
  assign scene_start_out = scene_start_q;
  assign timeout_out     = timeout_q;

endmodule

// File: tb/tb_scene_sequencer.sv
module tb_scene_sequencer;

  localparam int unsigned TMO = 100;
  localparam logic [3:0] S_IDLE   = 4'b1010;
  localparam logic [3:0] S_MENU   = 4'b0000;
  localparam logic [3:0] S_PLAY   = 4'b0001;
  localparam logic [3:0] S_RESULT = 4'b0010;
  localparam logic [3:0] S_ERROR  = 4'b1111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic busy = 1'b1;
  logic mf = 1'b0;
  logic pf = 1'b0;
  logic rf = 1'b0;
  logic [3:0] state_out;
  logic scene_start_out;
  logic timeout_out;

  always #5 clk = ~clk;

  scene_sequencer #(.TIMEOUT_CYCLES(TMO), .IDLE_CODE(4'b1010)) dut (
    .clk(clk),
    .rst(rst),
    .btn_start_in(btn),
    .menu_busy_in(busy),
    .menu_finished_in(mf),
    .play_finished_in(pf),
    .result_finished_in(rf),
    .state_out(state_out),
    .scene_start_out(scene_start_out),
    .timeout_out(timeout_out)
  );

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  // Scene-level view: which scene we are in, how many cycles it has lasted,
  // whether busy was observed, and the previous button level.
  logic [3:0] m_state = S_IDLE;
  logic       m_start = 1'b0;
  logic       m_timeout = 1'b0;
  int         m_age = 0;
  bit         m_busy_ok = 1'b0;
  logic       m_btn_prev = 1'b1;

  task automatic model_step();
    bit start_ev;
    bit timed_out;
    logic [3:0] nxt;
    if (rst) begin
      m_state = S_IDLE; m_start = 0; m_timeout = 0;
      m_age = 0; m_busy_ok = 0; m_btn_prev = 1;
      return;
    end
    start_ev = btn && !m_btn_prev;
    m_btn_prev = btn;
    timed_out = (m_age == int'(TMO) - 1);
    nxt = m_state;
    if (m_state == S_IDLE && start_ev) nxt = S_MENU;
    else if (m_state == S_ERROR && start_ev) nxt = S_IDLE;
    else if (m_state == S_MENU) begin
      if (mf) nxt = S_PLAY;
      else if (timed_out) nxt = S_ERROR;
`ifdef SCENE_BUSY_CHECK_EN
      else if (m_age == 3 && !m_busy_ok && !busy) nxt = S_ERROR;
`endif
    end
    else if (m_state == S_PLAY) nxt = pf ? S_RESULT : (timed_out ? S_ERROR : S_PLAY);
    else if (m_state == S_RESULT) nxt = rf ? S_MENU : (timed_out ? S_ERROR : S_RESULT);
    if (m_state == S_MENU && busy) m_busy_ok = 1;
    if (nxt != m_state) begin
      m_age = 0; m_busy_ok = 0; m_start = 1;
    end else begin
      m_start = 0;
      if (nxt == S_MENU || nxt == S_PLAY || nxt == S_RESULT) m_age = m_age + 1;
    end
    m_timeout = (nxt == S_ERROR);
    m_state = nxt;
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock: model samples the same inputs as the DUT, then outputs
  // are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse(input int which);
    if (which == 0) mf = 1; else if (which == 1) pf = 1; else rf = 1;
    tick();
    mf = 0; pf = 0; rf = 0;
  endtask

  task automatic press();
    btn = 0; tick();
    btn = 1; tick();
  endtask

  task automatic do_reset();
    rst = 1; repeat (3) tick(); rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    btn = 0; busy = 1;
    do_reset();
    n_checks++; if (state_out !== S_IDLE) begin n_fail++; $display("FAIL reset_state got=%b exp=%b", state_out, S_IDLE); end
    n_checks++; if (scene_start_out !== 1'b0) begin n_fail++; $display("FAIL reset_start got=%b exp=0", scene_start_out); end
    n_checks++; if (timeout_out !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", timeout_out); end
    tick();
    n_checks++; if (state_out !== S_IDLE) begin n_fail++; $display("FAIL idle_hold got=%b exp=%b", state_out, S_IDLE); end
  endtask

  task automatic test_start();
    btn = 1; tick();
    n_checks++; if (state_out !== S_MENU) begin n_fail++; $display("FAIL start_menu got=%b exp=%b", state_out, S_MENU); end
    n_checks++; if (scene_start_out !== 1'b1) begin n_fail++; $display("FAIL start_pulse got=%b exp=1", scene_start_out); end
    tick();
    n_checks++; if (scene_start_out !== 1'b0) begin n_fail++; $display("FAIL start_pulse_once got=%b exp=0", scene_start_out); end
    n_checks++; if (state_out !== S_MENU) begin n_fail++; $display("FAIL held_btn_menu got=%b exp=%b", state_out, S_MENU); end
    btn = 0;
  endtask

  task automatic test_scene_flow();
    logic [3:0] exp_seq [3];
    exp_seq[0] = S_PLAY; exp_seq[1] = S_RESULT; exp_seq[2] = S_MENU;
    for (int k = 0; k < 3; k++) begin
      while (m_age < 9) tick();
      pulse(k);
      n_checks++; if (state_out !== exp_seq[k] || scene_start_out !== 1'b1)
        begin n_fail++; $display("FAIL flow_%0d got=%b/%b exp=%b/1", k, state_out, scene_start_out, exp_seq[k]); end
      tick();
      n_checks++; if (scene_start_out !== 1'b0) begin n_fail++; $display("FAIL flow_pulse_%0d got=%b exp=0", k, scene_start_out); end
    end
  endtask

  task automatic test_timeout();
    pulse(0); // MENU -> PLAY
    n_checks++; if (state_out !== S_PLAY) begin n_fail++; $display("FAIL tmo_enter_play got=%b exp=%b", state_out, S_PLAY); end
    for (int i = 1; i < int'(TMO); i++) begin
      tick();
      n_checks++; if (state_out !== S_PLAY) begin n_fail++; $display("FAIL tmo_wait_%0d got=%b exp=%b", i, state_out, S_PLAY); end
    end
    tick();
    n_checks++; if (state_out !== S_ERROR || timeout_out !== 1'b1)
      begin n_fail++; $display("FAIL tmo_error got=%b/%b exp=1111/1", state_out, timeout_out); end
    repeat (5) tick();
    n_checks++; if (state_out !== S_ERROR) begin n_fail++; $display("FAIL tmo_error_hold got=%b exp=1111", state_out); end
    press();
    n_checks++; if (state_out !== S_IDLE || timeout_out !== 1'b0 || scene_start_out !== 1'b1)
      begin n_fail++; $display("FAIL tmo_recover got=%b/%b/%b exp=1010/0/1", state_out, timeout_out, scene_start_out); end
    btn = 0;
  endtask

  task automatic test_ignored();
    int n;
    press(); btn = 0;
    pulse(1); pulse(2);
    n_checks++; if (state_out !== S_MENU) begin n_fail++; $display("FAIL ign_menu got=%b exp=%b", state_out, S_MENU); end
    pulse(0);
    press(); btn = 0;
    pulse(0); pulse(2);
    n_checks++; if (state_out !== S_PLAY) begin n_fail++; $display("FAIL ign_play got=%b exp=%b", state_out, S_PLAY); end
    n = 0;
    while (m_age != int'(TMO) - 1 && n < 300) begin tick(); n++; end
    n_checks++; if (n >= 300) begin n_fail++; $display("FAIL ign_wait_budget got=%0d exp<300", n); end
    pulse(1);
    n_checks++; if (state_out !== S_RESULT || timeout_out !== 1'b0)
      begin n_fail++; $display("FAIL done_beats_timeout got=%b/%b exp=0010/0", state_out, timeout_out); end
  endtask

  task automatic test_busy();
    do_reset();
    busy = 0;
    press(); btn = 0;
    repeat (3) tick();
    n_checks++; if (state_out !== S_MENU) begin n_fail++; $display("FAIL busy_window got=%b exp=%b", state_out, S_MENU); end
    tick();
`ifdef SCENE_BUSY_CHECK_EN
    n_checks++; if (state_out !== S_ERROR || timeout_out !== 1'b1)
      begin n_fail++; $display("FAIL busy_missing got=%b/%b exp=1111/1", state_out, timeout_out); end
`else
    n_checks++; if (state_out !== S_MENU) begin n_fail++; $display("FAIL busy_ignored got=%b exp=%b", state_out, S_MENU); end
`endif
    do_reset();
    press(); btn = 0;
    tick();
    busy = 1; tick(); busy = 0;
    repeat (10) tick();
    n_checks++; if (state_out !== S_MENU) begin n_fail++; $display("FAIL busy_seen got=%b exp=%b", state_out, S_MENU); end
    busy = 1;
  endtask

  task automatic test_reset_mid();
    rst = 1; btn = 1; repeat (3) tick();
    rst = 0; tick(); tick();
    n_checks++; if (state_out !== S_IDLE || scene_start_out !== 1'b0)
      begin n_fail++; $display("FAIL held_btn_rst got=%b/%b exp=1010/0", state_out, scene_start_out); end
    press(); btn = 0;
    pulse(0); pulse(1);
    n_checks++; if (state_out !== S_RESULT) begin n_fail++; $display("FAIL mid_to_result got=%b exp=%b", state_out, S_RESULT); end
    tick();
    rst = 1; tick(); rst = 0;
    n_checks++; if (state_out !== S_IDLE || scene_start_out !== 1'b0)
      begin n_fail++; $display("FAIL mid_reset got=%b/%b exp=1010/0", state_out, scene_start_out); end
  endtask

  task automatic test_random();
    int p;
    for (int i = 0; i < 6000; i++) begin
      p = (i < 3000) ? 8 : 150;
      rst  = ($urandom_range(0, 499) == 0);
      btn  = ($urandom_range(0, 5) == 0) ? ~btn : btn;
      busy = ($urandom_range(0, 3) == 0);
      mf   = ($urandom_range(0, p) == 0);
      pf   = ($urandom_range(0, p) == 0);
      rf   = ($urandom_range(0, p) == 0);
      tick();
      n_checks++;
      if ({state_out, scene_start_out, timeout_out} !== {m_state, m_start, m_timeout}) begin
        n_fail++;
        $display("FAIL rand_%0d got=%b/%b/%b exp=%b/%b/%b", i, state_out, scene_start_out,
                 timeout_out, m_state, m_start, m_timeout);
      end
    end
    rst = 0; mf = 0; pf = 0; rf = 0; busy = 1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_start();
    test_scene_flow();
    test_timeout();
    test_ignored();
    test_busy();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
